alu_wb_ctrl: RTL and testbench
==============================

Name: alu_wb_ctrl

Overview:
- Execute/writeback stage that sits directly around the 8x8 register file: it accepts one ALU instruction at a time, drives the file's read ports (RX/RY) and captures busX/busY.
- It computes the result, including an iterative 8-cycle multiply, and drives the write port (WEN/RW/busW) for one cycle.
- It is the sole writer of the register file.

Parameters:
- DATA_W, 8, operand/result width; must match register file data width.
- ADDR_W, 3, register index width; must match register file address width.
- MUL_CYCLES, 8, EXEC cycles for MUL; must equal DATA_W.

Ports:
- Clk  in  1  clock; all state updates on posedge Clk.
- Rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept; high only in IDLE and Rst low.
- in_op  in  3  opcode.
- in_rd  in  ADDR_W  destination register.
- in_rs  in  ADDR_W  source A index.
- in_rt  in  ADDR_W  source B index.
- RX  out  ADDR_W  to register file read port X (= latched rs).
- RY  out  ADDR_W  to register file read port Y (= latched rt).
- busX  in  DATA_W  operand A from register file.
- busY  in  DATA_W  operand B from register file.
- WEN  out  1  register file write enable.
- RW  out  ADDR_W  register file write index.
- busW  out  DATA_W  register file write data.
- done  out  1  one-cycle pulse in the WB cycle.
- zero_flag  out  1  result==0; registered and updated at the end of WB.
- carry_flag  out  1  carry/borrow of the last op; registered and updated at the end of WB.

Behaviour:
- Reset (Rst high at posedge): state=IDLE; RX=RY=RW=0; busW=0; WEN=0; done=0; zero_flag=carry_flag=0; in_ready=0 while Rst high.
- Reset mid-operation abandons the instruction; no write occurs.
- Handshake: accept on posedge where in_valid && in_ready. op/rd/rs/rt are latched. in_ready drops the next cycle. in_valid without in_ready is ignored and nothing is latched.
- FSM IDLE -> READ -> EXEC -> WB -> IDLE.
  - IDLE: in_ready=1.
  - READ (1 cycle): RX/RY show the latched rs/rt; busX/busY are captured at end of cycle into opA/opB. The register file read is combinational.
  - EXEC: 1 cycle for non-MUL ops, MUL_CYCLES cycles for MUL, using a down-counter.
  - WB (1 cycle): WEN=(rd!=0), RW=rd, busW=result, done=1. Flags are updated at the end of WB.
- Latency with accept at cycle T: WB at T+3 (non-MUL) or T+10 (MUL). Next accept is possible at WB+1. Because the write has completed before the next READ, no forwarding or hazard logic is required.
- Outside WB: WEN=0, done=0; busW and RW hold their last values.
- Opcodes (result is 8-bit, wrap-around):
  - 000 ADD: carry=bit 8 of opA+opB.
  - 001 SUB: carry=borrow (opA<opB unsigned).
  - 010 AND, 011 OR, 100 XOR: carry=0.
  - 101 SLL by opB[2:0]: carry=0.
  - 110 SRL (logical) by opB[2:0]: carry=0.
  - 111 MUL: low 8 bits of opA*opB, carry=0.
- MUL is shift-add, fixed MUL_CYCLES iterations, with no early termination.
  - Start: acc=0, mcand=opA, mplier=opB.
  - Each cycle: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1.
- rd==0: WEN stays 0, since r0 is hardwired zero. done and flags still update.
- rs==rt is legal; both ports read the same register.

Decomposition:
- Package alu_wb_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding (S_IDLE, S_READ, S_EXEC, S_WB), MUL_CYCLES default.
- Sub-module alu_mul_seq: start/busy/done iterative multiplier with 8-bit inputs and 8-bit product. alu_wb_ctrl instantiates it during EXEC for MUL.
- All other ops are inline combinational.

Test Plan:
- Preload r1=8'h0F, r2=8'hF3; ADD rd=3 rs=1 rt=2 accepted at T -> WEN=1, RW=3, busW=8'h02, done at T+3; carry_flag=1, zero_flag=0; r3 reads back 8'h02.
- r1=8'h05, r2=8'h05; SUB rd=4 rs=1 rt=2 -> busW=8'h00, zero_flag=1, carry_flag=0. Then SUB rd=4 rs=0 rt=1 -> busW=8'hFB, carry_flag=1.
- r1=8'h0D, r2=8'h0B; MUL rd=5 -> done exactly at T+10, busW=8'h8F (143). r1=8'h10, r2=8'h10: busW=8'h00, zero_flag=1.
- r1=8'h81, r2=8'h03: SLL rd=6 -> 8'h08; SRL rd=7 -> 8'h10. ADD rd=0 -> WEN stays 0, done pulses, r0 reads 0.
- Back-to-back: in_valid held high with 3 instructions -> in_ready high only in IDLE, accepts spaced 4 cycles apart. The second instruction reads the first one's rd and gets the updated value.
- Rst asserted during MUL EXEC cycle 4 -> next cycle IDLE, WEN=0, done=0, flags=0, target register unchanged. A new ADD then completes normally.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared opcodes, FSM encoding and default sizes for the execute/writeback stage.
package alu_wb_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 3;
    localparam int MUL_CYCLES_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, fixed CYCLES iterations.
module alu_mul_seq #(
    parameter int W      = 8,
    parameter int CYCLES = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] product_o
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [CW-1:0] cnt_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // done_o flags the final iteration; product_o already includes it.
    assign busy_o    = (cnt_q != '0);
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CW'(CYCLES);
        end else if (busy_o) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_wb_ctrl.sv
// Execute/writeback stage wrapped around the 8x8 register file; sole writer of the file.
module alu_wb_ctrl
    import alu_wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    output logic [ADDR_W-1:0] RX,
    output logic [ADDR_W-1:0] RY,
    input  logic [DATA_W-1:0] busX,
    input  logic [DATA_W-1:0] busY,
    output logic              WEN,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] busW,
    output logic              done,
    output logic              zero_flag,
    output logic              carry_flag
);

    state_t              state_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q, rs_q, rt_q;
    logic [DATA_W-1:0]   opa_q, opb_q;
    logic                wen_q, done_q;
    logic [ADDR_W-1:0]   rw_q;
    logic [DATA_W-1:0]   busw_q;
    logic                carry_res_q;
    logic                zero_q, carry_q;

    logic                mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0]   mul_product;
    logic [DATA_W:0]     sum, diff;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                exec_last;

    // Valid/ready: a transfer happens on a posedge where in_valid && in_ready;
    // in_valid without in_ready is ignored and nothing is latched.
    assign in_ready = (state_q == S_IDLE) && !Rst && !mul_busy;

    assign RX         = rs_q;
    assign RY         = rt_q;
    assign WEN        = wen_q;
    assign RW         = rw_q;
    assign busW       = busw_q;
    assign done       = done_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

    // Multiplier loads straight from the read buses at the same edge opA/opB are captured.
    assign mul_start = (state_q == S_READ) && (op_q == OP_MUL) && !mul_busy;

    alu_mul_seq #(
        .W      (DATA_W),
        .CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .start_i   (mul_start),
        .a_i       (busX),
        .b_i       (busY),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        sum       = {1'b0, opa_q} + {1'b0, opb_q};
        diff      = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res   = diff[DATA_W-1:0];
                alu_carry = diff[DATA_W];
            end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_SLL:  alu_res = opa_q << opb_q[2:0];
            OP_SRL:  alu_res = opa_q >> opb_q[2:0];
            default: alu_res = mul_product;
        endcase
    end

    assign exec_last = (op_q != OP_MUL) || mul_done;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
            rw_q        <= '0;
            busw_q      <= '0;
            carry_res_q <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q    <= in_op;
                        rd_q    <= in_rd;
                        rs_q    <= in_rs;
                        rt_q    <= in_rt;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    opa_q   <= busX;
                    opb_q   <= busY;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_last) begin
                        busw_q      <= alu_res;
                        rw_q        <= rd_q;
                        wen_q       <= (rd_q != '0);  // r0 is hardwired zero
                        done_q      <= 1'b1;
                        carry_res_q <= alu_carry;
                        state_q     <= S_WB;
                    end
                end
                default: begin
                    zero_q  <= (busw_q == '0);
                    carry_q <= carry_res_q;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Bench for alu_wb_ctrl: register-file model, directed scenarios and a randomized model check.
module tb_alu_wb_ctrl;
    import alu_wb_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW;
    logic       WEN, done, zero_flag, carry_flag;

    logic [7:0] rf [8];
    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    end

    // Register file: combinational read, write on posedge; stores r0 writes so a stray one shows up.
    assign busX = rf[RX];
    assign busY = rf[RY];
    always @(posedge Clk) if (WEN) rf[RW] <= busW;

    alu_wb_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .RX         (RX),
        .RY         (RY),
        .busX       (busX),
        .busY       (busY),
        .WEN        (WEN),
        .RW         (RW),
        .busW       (busW),
        .done       (done),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    // Reference: {carry, result} straight from the opcode definitions.
    function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned av = a;
        int unsigned bv = b;
        int unsigned x;
        case (op)
            3'd0: begin x = av + bv; return {x[8], x[7:0]}; end
            3'd1: begin x = av - bv; return {(av < bv), x[7:0]}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: begin x = av << (bv % 8); return {1'b0, x[7:0]}; end
            3'd6: begin x = av >> (bv % 8); return {1'b0, x[7:0]}; end
            default: begin x = av * bv; return {1'b0, x[7:0]}; end
        endcase
    endfunction

    task automatic preload(input logic [2:0] idx, input logic [7:0] val);
        @(negedge Clk);
        rf[idx] <= val;
    endtask

    // Drives one instruction and reports what the write port showed in WB plus the flags one cycle later.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, output int lat, output logic wen,
                         output logic [2:0] rw, output logic [7:0] w,
                         output logic zf, output logic cf, output logic to);
        lat = 0; wen = 1'bx; rw = 'x; w = 'x; zf = 1'bx; cf = 1'bx; to = 1'b0;
        @(negedge Clk);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge Clk);
        if (!in_ready) begin
            in_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(negedge Clk);
        in_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        if (!done) begin
            to = 1'b1;
            return;
        end
        wen = WEN; rw = RW; w = busW;
        @(negedge Clk);
        zf = zero_flag; cf = carry_flag;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        total++;
        if ({in_ready, WEN, done, RW, RX, RY, busW, zero_flag, carry_flag} !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b wen=%b done=%b rw=%0d rx=%0d ry=%0d busW=%h z=%b c=%b, want all 0",
                     in_ready, WEN, done, RW, RX, RY, busW, zero_flag, carry_flag);
        end
        Rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        preload(1, 8'h0F); preload(2, 8'hF3);
        issue(OP_ADD, 3, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 3 || wen !== 1'b1 || rw !== 3'd3 || w !== 8'h02) begin
            bad++;
            $display("FAIL add_wb: got to=%b lat=%0d wen=%b rw=%0d busW=%h want lat=3 wen=1 rw=3 busW=02", to, lat, wen, rw, w);
        end
        total++;
        if (zf !== 1'b0 || cf !== 1'b1 || rf[3] !== 8'h02) begin
            bad++;
            $display("FAIL add_flags: got z=%b c=%b r3=%h want z=0 c=1 r3=02", zf, cf, rf[3]);
        end
    endtask

    task automatic test_sub();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        preload(1, 8'h05); preload(2, 8'h05);
        issue(OP_SUB, 4, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 3 || w !== 8'h00 || zf !== 1'b1 || cf !== 1'b0) begin
            bad++;
            $display("FAIL sub_zero: got to=%b lat=%0d busW=%h z=%b c=%b want lat=3 busW=00 z=1 c=0", to, lat, w, zf, cf);
        end
        issue(OP_SUB, 4, 0, 1, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || w !== 8'hFB || zf !== 1'b0 || cf !== 1'b1 || rf[4] !== 8'hFB) begin
            bad++;
            $display("FAIL sub_borrow: got to=%b busW=%h z=%b c=%b r4=%h want busW=fb z=0 c=1 r4=fb", to, w, zf, cf, rf[4]);
        end
    endtask

    task automatic test_mul();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        preload(1, 8'h0D); preload(2, 8'h0B);
        issue(OP_MUL, 5, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 10 || wen !== 1'b1 || rw !== 3'd5 || w !== 8'h8F || zf !== 1'b0 || cf !== 1'b0) begin
            bad++;
            $display("FAIL mul_143: got to=%b lat=%0d wen=%b rw=%0d busW=%h z=%b c=%b want lat=10 wen=1 rw=5 busW=8f z=0 c=0",
                     to, lat, wen, rw, w, zf, cf);
        end
        preload(1, 8'h10); preload(2, 8'h10);
        issue(OP_MUL, 5, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 10 || w !== 8'h00 || zf !== 1'b1 || cf !== 1'b0) begin
            bad++;
            $display("FAIL mul_wrap: got to=%b lat=%0d busW=%h z=%b c=%b want lat=10 busW=00 z=1 c=0", to, lat, w, zf, cf);
        end
    endtask

    task automatic test_shift_r0();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        preload(1, 8'h81); preload(2, 8'h03);
        issue(OP_SLL, 6, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || w !== 8'h08 || cf !== 1'b0 || rf[6] !== 8'h08) begin
            bad++;
            $display("FAIL sll: got to=%b busW=%h c=%b r6=%h want busW=08 c=0 r6=08", to, w, cf, rf[6]);
        end
        issue(OP_SRL, 7, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || w !== 8'h10 || rf[7] !== 8'h10) begin
            bad++;
            $display("FAIL srl: got to=%b busW=%h r7=%h want busW=10 r7=10", to, w, rf[7]);
        end
        issue(OP_ADD, 0, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 3 || wen !== 1'b0 || w !== 8'h84 || rf[0] !== 8'h00) begin
            bad++;
            $display("FAIL add_r0: got to=%b lat=%0d wen=%b busW=%h r0=%h want lat=3 wen=0 busW=84 r0=00", to, lat, wen, w, rf[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [2:0] rds [3];
        logic [2:0] rss [3];
        logic [2:0] rts [3];
        int acc [3];
        int n = 0;
        int dones = 0;
        logic fire;
        ops[0] = OP_ADD; rds[0] = 3; rss[0] = 1; rts[0] = 2;
        ops[1] = OP_XOR; rds[1] = 4; rss[1] = 3; rts[1] = 1;
        ops[2] = OP_SUB; rds[2] = 5; rss[2] = 4; rts[2] = 2;
        for (int i = 0; i < 3; i++) acc[i] = -100;
        preload(1, 8'h21); preload(2, 8'h14);
        @(negedge Clk);
        in_valid = 1'b1; in_op = ops[0]; in_rd = rds[0]; in_rs = rss[0]; in_rt = rts[0];
        for (int c = 0; c < 24; c++) begin
            if (done) dones++;
            fire = in_valid && in_ready;
            @(negedge Clk);
            if (fire) begin
                acc[n] = c;
                n++;
                if (n < 3) begin
                    in_op = ops[n]; in_rd = rds[n]; in_rs = rss[n]; in_rt = rts[n];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (n != 3 || acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4 || dones != 3) begin
            bad++;
            $display("FAIL b2b_spacing: got accepts=%0d at %0d,%0d,%0d dones=%0d want 3 accepts 4 apart, 3 dones",
                     n, acc[0], acc[1], acc[2], dones);
        end
        total++;
        if (rf[3] !== 8'h35 || rf[4] !== 8'h14 || rf[5] !== 8'h00) begin
            bad++;
            $display("FAIL b2b_values: got r3=%h r4=%h r5=%h want r3=35 r4=14 r5=00", rf[3], rf[4], rf[5]);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        int dones = 0;
        preload(1, 8'hFF); preload(2, 8'h02);
        issue(OP_ADD, 6, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || w !== 8'h01 || carry_flag !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_add: got to=%b busW=%h c=%b want busW=01 c=1", to, w, carry_flag);
        end
        preload(5, 8'hAA); preload(1, 8'h0D); preload(2, 8'h0B);
        @(negedge Clk);
        in_valid = 1'b1; in_op = OP_MUL; in_rd = 5; in_rs = 1; in_rt = 2;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        total++;
        if (WEN !== 1'b0 || done !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_mul_reset: got wen=%b done=%b z=%b c=%b rdy=%b want all 0",
                     WEN, done, zero_flag, carry_flag, in_ready);
        end
        Rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_mul_idle: got rdy=%b want 1", in_ready);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (done || WEN) dones++;
        end
        total++;
        if (dones != 0 || rf[5] !== 8'hAA) begin
            bad++;
            $display("FAIL mid_mul_abandon: got late_writes=%0d r5=%h want 0 and aa", dones, rf[5]);
        end
        issue(OP_ADD, 7, 1, 2, lat, wen, rw, w, zf, cf, to);
        total++;
        if (to || lat != 3 || wen !== 1'b1 || rw !== 3'd7 || w !== 8'h18 || cf !== 1'b0 || rf[7] !== 8'h18) begin
            bad++;
            $display("FAIL post_reset_add: got to=%b lat=%0d wen=%b rw=%0d busW=%h c=%b want lat=3 wen=1 rw=7 busW=18 c=0",
                     to, lat, wen, rw, w, cf);
        end
    endtask

    task automatic test_random();
        int lat; logic wen, zf, cf, to; logic [2:0] rw; logic [7:0] w;
        logic [2:0] op, rd, rs, rt;
        logic [8:0] exp;
        int exp_lat;
        for (int k = 0; k < 40; k++) begin
            preload(3'($urandom_range(1, 7)), 8'($urandom_range(0, 255)));
            preload(3'($urandom_range(1, 7)), 8'($urandom_range(0, 255)));
            op = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
            rt = (k % 5 == 0) ? rs : 3'($urandom_range(0, 7));
            @(negedge Clk);
            exp = model(op, (rs == 0) ? 8'h00 : rf[rs], (rt == 0) ? 8'h00 : rf[rt]);
            exp_lat = (op == OP_MUL) ? 10 : 3;
            issue(op, rd, rs, rt, lat, wen, rw, w, zf, cf, to);
            total++;
            if (to || lat != exp_lat || wen !== (rd != 0) || rw !== rd || w !== exp[7:0]
                || zf !== (exp[7:0] == 8'h00) || cf !== exp[8]) begin
                bad++;
                $display("FAIL rand_%0d op=%0d rd=%0d rs=%0d rt=%0d: got to=%b lat=%0d wen=%b rw=%0d busW=%h z=%b c=%b want lat=%0d busW=%h c=%b",
                         k, op, rd, rs, rt, to, lat, wen, rw, w, zf, cf, exp_lat, exp[7:0], exp[8]);
            end
            total++;
            if (rf[0] !== 8'h00 || (rd != 0 && rf[rd] !== exp[7:0])) begin
                bad++;
                $display("FAIL rand_rf_%0d: got r0=%h r%0d=%h want r0=00 r%0d=%h", k, rf[0], rd, rf[rd], rd, exp[7:0]);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift_r0();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
